// File: rtl/pico_apb_master.sv
// -----------------------------------------------------------------------------
// pico_apb_master
//
// Bridge from the PicoRV32 native memory interface to an APB4 requester port.
// Each mem_valid/mem_ready transaction becomes one APB SETUP/ACCESS transfer.
// Read data from the slave is returned to the core. Only one transfer is ever
// in flight.
//
// Ports
//   clk, resetn              : clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb : core request (wstrb == 0 means read)
//   mem_ready, mem_rdata     : one-cycle completion pulse and read data
//   paddr, psel, penable,
//   pwrite, pwdata, pstrb    : APB requester outputs (all registered)
//   prdata, pready, pslverr  : APB completer responses
//   bus_err                  : one-cycle pulse on a slave error or a timeout
//
// Parameters
//   ADDR_WIDTH     : APB address width (3..32); paddr is word aligned
//   TIMEOUT_CYCLES : ACCESS cycles allowed before an abort (1..65535)
//
// Optional feature
//   PICO_APB_TIMEOUT_EN : when defined, ACCESS aborts after TIMEOUT_CYCLES
//                         cycles without pready. When undefined, ACCESS
//                         waits for pready indefinitely.
// -----------------------------------------------------------------------------
module pico_apb_master #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  // PicoRV32 native memory interface
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  // APB4 requester
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  // Error report
  output logic                  bus_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e                state_q,     state_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [31:0]           pwdata_q,    pwdata_d;
  logic [3:0]            pstrb_q,     pstrb_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  bus_err_q,   bus_err_d;

  // The byte-offset bits (and any bits above the APB address space) are
  // dropped on purpose; folding them here keeps that intent explicit.
  logic unused_addr;
  if (ADDR_WIDTH < 32) begin : g_addr_hi
    assign unused_addr = ^{mem_addr[31:ADDR_WIDTH], mem_addr[1:0]};
  end else begin : g_addr_full
    assign unused_addr = ^mem_addr[1:0];
  end

`ifdef PICO_APB_TIMEOUT_EN
  // Count of ACCESS cycles already spent without pready. The abort fires on
  // the edge where this count has reached TIMEOUT_CYCLES-1 and pready is
  // still low, i.e. after exactly TIMEOUT_CYCLES ACCESS cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TIMEOUT_CYCLES);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    mem_rdata_d = mem_rdata_q;
    mem_ready_d = 1'b0;   // pulses: high for a single cycle only
    bus_err_d   = 1'b0;
`ifdef PICO_APB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // mem_ready_q high means the core is retiring the previous request
        // this cycle and mem_valid still belongs to it; do not relaunch.
        if (mem_valid && !mem_ready_q) begin
          paddr_d   = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
          pwrite_d  = |mem_wstrb;
          pwdata_d  = mem_wdata;
          pstrb_d   = mem_wstrb;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
`ifdef PICO_APB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end

      S_ACCESS: begin
        // Address, control and data registers simply hold here. mem_valid
        // is not looked at: once launched, a transfer always completes.
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          mem_ready_d = 1'b1;
          bus_err_d   = pslverr;
          // Errored reads still pass the slave's data through unchanged.
          if (!pwrite_q) begin
            mem_rdata_d = prdata;
          end
          state_d = S_IDLE;
        end
`ifdef PICO_APB_TIMEOUT_EN
        // pready is tested first, so a response on the limit edge wins.
        else if (tmo_cnt_q == TMO_LAST) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          mem_ready_d = 1'b1;
          bus_err_d   = 1'b1;
          if (!pwrite_q) begin
            mem_rdata_d = 32'hFFFF_FFFF;
          end
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: the reset branch is asynchronous so a reset in the middle of a
  // transfer drops psel/penable and suppresses mem_ready without waiting for
  // a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous state, independent of statement order.
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

`ifdef PICO_APB_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  // Every output comes straight from a register.
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_pico_apb_master.sv
// -----------------------------------------------------------------------------
// tb_pico_apb_master
//
// Self-checking bench for pico_apb_master. Inputs are driven and outputs are
// sampled on the falling clock edge. The reference model works at the
// transaction level: expected address, strobes, latency (3 + wait states, or
// 2 + TIMEOUT_CYCLES on an abort), error flag, and the core-visible read-data
// register are all computed from the request and the slave's behaviour.
// -----------------------------------------------------------------------------
module tb_pico_apb_master;

  localparam int AW = 16;
`ifdef PICO_APB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif
  localparam int MAXW = (TMO > 6) ? 5 : TMO - 1;   // random wait-state range
  localparam logic [31:0] AMASK = 32'h0000_FFFC;     // word-aligned, AW bits

  logic          clk = 1'b0;
  logic          resetn;
  logic          mem_valid;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic          bus_err;

  int checks = 0;
  int errors = 0;

  // Core-visible read-data register as the model sees it.
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  pico_apb_master #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .bus_err   (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete core transaction. Called on a falling edge; returns on the
  // falling edge of the cycle after mem_ready, with mem_valid low.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int waits,
                          input logic [31:0] rdata, input logic slverr,
                          input bit expect_tmo, input bit drop_valid);
    logic [31:0] exp_paddr;
    logic [31:0] exp_rd;
    int          exp_lat;
    bit          done;
    exp_paddr = addr & AMASK;
    exp_lat   = expect_tmo ? 2 + TMO : 3 + waits;
    if (wstrb != 4'b0000)
      exp_rd = model_rdata;
    else
      exp_rd = expect_tmo ? 32'hFFFF_FFFF : rdata;

    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    pready    = 1'b0;
    done      = 1'b0;

    for (int c = 1; c <= waits + TMO + 8 && !done; c++) begin
      step();
      if (mem_ready) begin
        check("latency",       c,                exp_lat);
        check("rdata",         mem_rdata,        exp_rd);
        check("bus_err",       32'(bus_err),     32'(expect_tmo | slverr));
        check("psel_done",     32'(psel),        32'd0);
        check("penable_done",  32'(penable),     32'd0);
        model_rdata = exp_rd;
        pready      = 1'b0;
        done        = 1'b1;
      end else begin
        check(c == 1 ? "psel_setup" : "psel_access", 32'(psel), 32'd1);
        check(c == 1 ? "penable_setup" : "penable_access", 32'(penable), 32'(c != 1));
        check("paddr",   32'(paddr),   exp_paddr);
        check("pwrite",  32'(pwrite),  32'(wstrb != 4'b0000));
        check("pstrb",   32'(pstrb),   32'(wstrb));
        check("pwdata",  pwdata,       wdata);
        check("bus_err_busy", 32'(bus_err), 32'd0);
        if (drop_valid && c == 1) mem_valid = 1'b0;
        if (!expect_tmo && c == 2 + waits) begin
          pready  = 1'b1;
          prdata  = rdata;
          pslverr = slverr;
        end else begin
          // Junk on the response lines must be ignored while pready is low.
          pready  = 1'b0;
          prdata  = $urandom;
          pslverr = 1'($urandom);
        end
      end
    end
    if (!done) check("mem_ready_seen", 32'd0, 32'd1);
    pslverr = 1'b0;

    // mem_valid is still high for the retiring request: nothing may launch.
    step();
    check("no_relaunch",  32'(psel),      32'd0);
    check("ready_pulse",  32'(mem_ready), 32'd0);
    check("err_pulse",    32'(bus_err),   32'd0);
    mem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    model_rdata = '0;

    repeat (3) @(negedge clk);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_mem_rdata", mem_rdata,      32'd0);
    check("rst_psel",      32'(psel),      32'd0);
    check("rst_penable",   32'(penable),   32'd0);
    check("rst_pwrite",    32'(pwrite),    32'd0);
    check("rst_paddr",     32'(paddr),     32'd0);
    check("rst_pwdata",    pwdata,         32'd0);
    check("rst_pstrb",     32'(pstrb),     32'd0);
    check("rst_bus_err",   32'(bus_err),   32'd0);
    resetn = 1'b1;
    step();

    // Zero-wait read.
    run_xfer(32'h0000_1234, 32'h0, 4'b0000, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    step();
    // Write with three wait states.
    run_xfer(32'h0000_2008, 32'h1122_3344, 4'b0110, 3, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
    step();
    // Write that the slave errors.
    run_xfer(32'hABCD_0010, 32'h5566_7788, 4'b1111, 1, 32'h0, 1'b1, 1'b0, 1'b0);
    // Back-to-back read then write, no idle cycles inserted by the core.
    run_xfer(32'h0000_0040, 32'h0, 4'b0000, 0, 32'h0BAD_BEEF, 1'b0, 1'b0, 1'b0);
    run_xfer(32'h0000_0044, 32'h9999_AAAA, 4'b0001, 0, 32'h1357_9BDF, 1'b0, 1'b0, 1'b0);
    // Errored read: data is passed through, error flagged.
    run_xfer(32'h0000_0F0F, 32'h0, 4'b0000, 2, 32'h2468_ACE0, 1'b1, 1'b0, 1'b0);
    // mem_valid dropped mid-transfer: transfer still completes.
    run_xfer(32'h0000_3000, 32'h0, 4'b0000, 1, 32'h7777_1111, 1'b0, 1'b0, 1'b1);

    // Reset during ACCESS.
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_4444;
    mem_wstrb = 4'b0000;
    step();                      // SETUP
    step();                      // ACCESS
    check("pre_rst_penable", 32'(penable), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_psel",    32'(psel),      32'd0);
    check("rst_mid_penable", 32'(penable),   32'd0);
    check("rst_mid_ready",   32'(mem_ready), 32'd0);
    check("rst_mid_rdata",   mem_rdata,      32'd0);
    model_rdata = '0;
    pready = 1'b1;
    prdata = 32'hFEED_FACE;
    repeat (2) step();
    check("rst_hold_ready",  32'(mem_ready), 32'd0);
    check("rst_hold_psel",   32'(psel),      32'd0);
    pready    = 1'b0;
    mem_valid = 1'b0;
    resetn    = 1'b1;
    step();
    run_xfer(32'h0000_4444, 32'h0, 4'b0000, 1, 32'h4444_5555, 1'b0, 1'b0, 1'b0);

`ifdef PICO_APB_TIMEOUT_EN
    // pready on the limit edge completes normally.
    run_xfer(32'h0000_5000, 32'h0, 4'b0000, TMO - 1, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0);
    // Slave never answers: abort after TMO ACCESS cycles.
    run_xfer(32'h0000_6000, 32'h0, 4'b0000, 100, 32'h0, 1'b0, 1'b1, 1'b0);
    run_xfer(32'h0000_6004, 32'hCCCC_DDDD, 4'b1000, 100, 32'h0, 1'b0, 1'b1, 1'b0);
`else
    // Without the timeout a long stall must simply wait.
    run_xfer(32'h0000_5000, 32'h0, 4'b0000, 40, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0);
`endif

    // Randomized transactions.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, wd, rd;
      logic [3:0]  ws;
      int          w, idle;
      a    = $urandom;
      wd   = $urandom;
      rd   = $urandom;
      ws   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      w    = $urandom_range(0, MAXW);
      idle = $urandom_range(0, 2);
      run_xfer(a, wd, ws, w, rd, ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
      repeat (idle) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_apb_master.md
# pico_apb_master

Bridge from the PicoRV32 native memory interface to an APB4 requester port, so the RISC-V core can issue reads and writes to APB peripherals in the fabric. It converts one `mem_valid`/`mem_ready` transaction into one APB SETUP/ACCESS transfer and returns the slave's read data to the core. It sits between the `picorv32` instance and the APB peripheral address decoder, on the core side of the shared-RAM subsystem.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: APB address width; `paddr = {mem_addr[ADDR_WIDTH-1:2], 2'b00}`.
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles before abort (used only with `PICO_APB_TIMEOUT_EN`); legal range 1..65535.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: core request.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte enables; 0 = read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data, valid while `mem_ready`=1.
- `paddr` out ADDR_WIDTH: APB address.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB write.
- `pwdata` out 32: APB write data.
- `pstrb` out 4: APB write strobes (0 on reads).
- `prdata` in 32: slave read data.
- `pready` in 1: slave ready.
- `pslverr` in 1: slave error.
- `bus_err` out 1: one-cycle pulse on `pslverr` or timeout completion.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if `mem_valid`=1 and `mem_ready`=0, latch `paddr`, `pwrite=|mem_wstrb`, `pwdata`, `pstrb=mem_wstrb`; go to SETUP.
- SETUP: `psel`=1, `penable`=0; unconditionally go to ACCESS.
- ACCESS: `psel`=1, `penable`=1; hold all address/control/data stable. When `pready`=1: register `prdata` into `mem_rdata` (reads; writes leave `mem_rdata` unchanged), assert `mem_ready` next cycle, `bus_err` next cycle if `pslverr`=1, return to IDLE with `psel`=`penable`=0.
- `pslverr` does not stall the core: transfer completes normally; read data from an errored read is passed through unchanged.
- The IDLE guard on `mem_ready` prevents re-launching a request the core is retiring in the same cycle.
- No outstanding-transfer queue: exactly one APB transfer in flight.
- `mem_valid` dropping mid-transfer (not legal for PicoRV32) is ignored; the transfer completes and `mem_ready` still pulses.
- Reset mid-transfer: all outputs return immediately to reset values; FSM to IDLE; no `mem_ready`.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `pstrb`=0, `bus_err`=0.
- All outputs registered.
- Zero-wait slave: `mem_valid` sampled at edge 1, SETUP cycle 1, ACCESS cycle 2, `pready` sampled edge 3, `mem_ready`=1 in cycle 3. Latency = 3 cycles + N wait states.
- Back-to-back: next request accepted the cycle after `mem_ready`; minimum 1 IDLE cycle between transfers.

## Configuration
- `PICO_APB_TIMEOUT_EN` defined: counter clears on entering ACCESS, increments each ACCESS cycle with `pready`=0; on reaching `TIMEOUT_CYCLES`, abort: `psel`/`penable` drop, `mem_ready`=1 and `bus_err`=1 next cycle, `mem_rdata`=32'hFFFF_FFFF for reads. `pready` arriving on the same edge as the limit wins (normal completion, no error).
- Not defined: no counter; ACCESS waits indefinitely for `pready`.

## Test plan
- Read, zero-wait slave, `mem_addr`=0x0000_1234, `prdata`=0xCAFE_F00D -> `paddr`=0x1234, `pstrb`=0, `mem_ready` in cycle 3 with `mem_rdata`=0xCAFE_F00D, `bus_err`=0.
- Write `mem_wstrb`=4'b0110, `mem_wdata`=0x1122_3344, slave 3 wait states -> `pwrite`=1, `pstrb`=0110, `pwdata` stable through ACCESS, `mem_ready` in cycle 6.
- Write with `pslverr`=1 on completion -> `mem_ready` and `bus_err` both pulse one cycle.
- Back-to-back read then write -> second SETUP begins 1 cycle after first `mem_ready`, no duplicate transfer.
- `resetn` low during ACCESS -> `psel`/`penable` 0 immediately, no `mem_ready`; next request after reset completes normally.
- With `PICO_APB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `pready` held 0 on a read -> abort after 4 ACCESS cycles, `mem_rdata`=0xFFFF_FFFF, `bus_err`=1.
